jtag_dtm_tap: RTL

IEEE 1149.1 TAP controller for the RISC-V debug transport module (DTM). Sits directly upstream of the DMI-access/JTAG-side request logic and runs in the tck domain. It decodes TMS into the 16-state TAP FSM and holds the 5-bit instruction register and the IDCODE, DTMCS and BYPASS data registers. It exports shift/capture/update strobes, register selects and the TDI/TDO path for the DMI data register, which is implemented downstream.

---
 rtl/jtag_dtm_tap.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP controller for the RISC-V debug transport module.
// Decodes TMS into the 16-state TAP FSM and holds the IR and the IDCODE,
// DTMCS and BYPASS data registers. The DMI data register lives downstream;
// only its serial in/out is routed here.
module jtag_dtm_tap #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001
) (
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       testmode_i,
    input  logic       tms_i,
    input  logic       td_i,
    output logic       td_o,
    output logic       tdo_oe_o,
    output logic       test_logic_reset_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_dr_o,
    output logic       dmi_access_o,
    output logic       dtmcs_select_o,
    output logic       dmi_reset_o,
    input  logic [1:0] dmi_error_i,
    output logic       dmi_tdi_o,
    input  logic       dmi_tdo_i
);

    typedef enum logic [3:0] {
        StTestLogicReset, StRunTestIdle,
        StSelectDrScan, StCaptureDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr, StUpdateDr,
        StSelectIrScan, StCaptureIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdateIr
    } tap_state_e;

    localparam logic [IrLength-1:0] IrIdcode    = 5'h01;
    localparam logic [IrLength-1:0] IrDtmcs     = 5'h10;
    localparam logic [IrLength-1:0] IrDmiAccess = 5'h11;
    localparam logic [IrLength-1:0] IrCapture   = 5'b00101;

    tap_state_e          r_state_q, w_state_d;
    logic [IrLength-1:0] r_ir_shift_q;
    logic [IrLength-1:0] r_ir_q;
    logic [31:0]         r_idcode_q;
    logic [31:0]         r_dtmcs_q;
    logic                r_bypass_q;
    logic                r_td_q, r_oe_q;
    logic                w_td_d, w_oe_d;
    logic                w_idcode_sel, w_bypass_sel;
    logic                w_tdo_clk;

    // TAP state register
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_state_q <= StTestLogicReset;
        else          r_state_q <= w_state_d;
    end

    // IEEE 1149.1 TMS transition table
    always_comb begin
        w_state_d = r_state_q;
        unique case (r_state_q)
            StTestLogicReset: w_state_d = tms_i ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    w_state_d = tms_i ? StSelectDrScan   : StRunTestIdle;
            StSelectDrScan:   w_state_d = tms_i ? StSelectIrScan   : StCaptureDr;
            StCaptureDr:      w_state_d = tms_i ? StExit1Dr        : StShiftDr;
            StShiftDr:        w_state_d = tms_i ? StExit1Dr        : StShiftDr;
            StExit1Dr:        w_state_d = tms_i ? StUpdateDr       : StPauseDr;
            StPauseDr:        w_state_d = tms_i ? StExit2Dr        : StPauseDr;
            StExit2Dr:        w_state_d = tms_i ? StUpdateDr       : StShiftDr;
            StUpdateDr:       w_state_d = tms_i ? StSelectDrScan   : StRunTestIdle;
            StSelectIrScan:   w_state_d = tms_i ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      w_state_d = tms_i ? StExit1Ir        : StShiftIr;
            StShiftIr:        w_state_d = tms_i ? StExit1Ir        : StShiftIr;
            StExit1Ir:        w_state_d = tms_i ? StUpdateIr       : StPauseIr;
            StPauseIr:        w_state_d = tms_i ? StExit2Ir        : StPauseIr;
            StExit2Ir:        w_state_d = tms_i ? StUpdateIr       : StShiftIr;
            StUpdateIr:       w_state_d = tms_i ? StSelectDrScan   : StRunTestIdle;
            default:          w_state_d = StTestLogicReset;
        endcase
    end

    // IR shift register: capture fixed pattern, shift right with TDI into MSB
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir_shift_q <= '0;
        end else if (r_state_q == StCaptureIr) begin
            r_ir_shift_q <= IrCapture;
        end else if (r_state_q == StShiftIr) begin
            r_ir_shift_q <= {td_i, r_ir_shift_q[IrLength-1:1]};
        end
    end

    // Instruction register; reloaded with IDCODE whenever TestLogicReset is entered
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir_q <= IrIdcode;
        end else if (w_state_d == StTestLogicReset) begin
            r_ir_q <= IrIdcode;
        end else if (r_state_q == StUpdateIr) begin
            r_ir_q <= r_ir_shift_q;
        end
    end

    // Instruction decode; every unlisted code (including 5'h1F and 5'h00) is BYPASS
    always_comb begin
        w_idcode_sel   = (r_ir_q == IrIdcode);
        dtmcs_select_o = (r_ir_q == IrDtmcs);
        dmi_access_o   = (r_ir_q == IrDmiAccess);
        w_bypass_sel   = !(w_idcode_sel || dtmcs_select_o || dmi_access_o);
    end

    // Data registers: capture/shift only when selected, hold in Pause/Exit
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_idcode_q <= IdcodeValue;
            r_dtmcs_q  <= '0;
            r_bypass_q <= 1'b0;
        end else if (r_state_q == StCaptureDr) begin
            if (w_idcode_sel)   r_idcode_q <= IdcodeValue;
            if (dtmcs_select_o) r_dtmcs_q  <= {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmi_error_i,
                                               6'd7, 4'd1};
            if (w_bypass_sel)   r_bypass_q <= 1'b0;
        end else if (r_state_q == StShiftDr) begin
            if (w_idcode_sel)   r_idcode_q <= {td_i, r_idcode_q[31:1]};
            if (dtmcs_select_o) r_dtmcs_q  <= {td_i, r_dtmcs_q[31:1]};
            if (w_bypass_sel)   r_bypass_q <= td_i;
        end
    end

    // State strobes and dmireset pulse
    always_comb begin
        test_logic_reset_o = (r_state_q == StTestLogicReset);
        capture_dr_o       = (r_state_q == StCaptureDr);
        shift_dr_o         = (r_state_q == StShiftDr);
        update_dr_o        = (r_state_q == StUpdateDr);
        dmi_reset_o        = dtmcs_select_o & update_dr_o & r_dtmcs_q[16];
        dmi_tdi_o          = td_i;
    end

    // TDO source select; td_o holds its previous value outside the shift states
    always_comb begin
        w_td_d = r_td_q;
        w_oe_d = 1'b0;
        if (r_state_q == StShiftIr) begin
            w_td_d = r_ir_shift_q[0];
            w_oe_d = 1'b1;
        end else if (r_state_q == StShiftDr) begin
            w_oe_d = 1'b1;
            if (w_idcode_sel)        w_td_d = r_idcode_q[0];
            else if (dtmcs_select_o) w_td_d = r_dtmcs_q[0];
            else if (dmi_access_o)   w_td_d = dmi_tdo_i;
            else                     w_td_d = r_bypass_q;
        end
    end

    // In scan mode the TDO flop must see the true clock, not its inversion
    assign w_tdo_clk = testmode_i ? tck_i : ~tck_i;

    // TDO output flops, launched on the falling edge of tck
    always_ff @(posedge w_tdo_clk or negedge trst_ni) begin
        if (!trst_ni) begin
            r_td_q <= 1'b0;
            r_oe_q <= 1'b0;
        end else begin
            r_td_q <= w_td_d;
            r_oe_q <= w_oe_d;
        end
    end

    assign td_o     = r_td_q;
    assign tdo_oe_o = r_oe_q;

endmodule
